freq_meter: RTL and testbench

Gated-window frequency counter that measures an external square wave against the system clock, reporting edges per window. It is the measuring counterpart of the cascaded clock-divider chain: it lets the board self-check the generated divider taps (1 MHz, 10 kHz, 100 Hz, …) or any external periodic signal. It sits on the 100 MHz system domain and feeds its binary result to the display and check logic.

---
 rtl/freq_meter.sv | 114 +++++++++++
 tb/tb_freq_meter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated-window frequency counter: counts rising edges of an asynchronous input
// over GATE_CYCLES clk_ref cycles and reports a saturating count.
module freq_meter #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf
);

  localparam int TMR_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             w_edge;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_freq;
  logic             r_ovf;
  logic [CNT_W-1:0] w_cnt_upd;
  logic             w_sat_upd;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the synchronizer really is a shift chain.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_prev;

  always_ff @(posedge clk_ref) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_GATE;
      S_GATE:  if (r_timer == '0) w_state_next = S_DONE;
      S_DONE:  w_state_next = cont ? S_GATE : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_upd = r_cnt;
    w_sat_upd = r_sat;
    if (w_edge) begin
      if (r_cnt == CNT_MAX) w_sat_upd = 1'b1;
      else                  w_cnt_upd = r_cnt + CNT_W'(1);
    end
  end

  // The result is latched on the last GATE edge so it is already visible
  // during the DONE cycle, together with valid.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_timer <= TMR_LOAD;
      r_freq  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_GATE: begin
          r_cnt   <= w_cnt_upd;
          r_sat   <= w_sat_upd;
          r_timer <= r_timer - TMR_W'(1);
          if (r_timer == '0) begin
            r_freq <= w_cnt_upd;
            r_ovf  <= w_sat_upd;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_sat   <= 1'b0;
          r_timer <= TMR_LOAD;
        end
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign valid = (r_state == S_DONE);
  assign freq  = r_freq;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two instances (8-bit and 4-bit result)
// share one stimulus; expected counts come from a log of sampled input rises.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int GC = 100;

  logic       clk_ref = 1'b0;
  logic       rst;
  logic       sig_in;
  logic       start;
  logic       cont;
  logic       busy8, valid8, ovf8;
  logic [7:0] freq8;
  logic       busy4, valid4, ovf4;
  logic [3:0] freq4;

  int n_checks = 0;
  int n_errors = 0;

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(8)) u_dut8 (
    .clk_ref(clk_ref), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy8), .freq(freq8), .valid(valid8), .ovf(ovf8)
  );

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(4)) u_dut4 (
    .clk_ref(clk_ref), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy4), .freq(freq4), .valid(valid4), .ovf(ovf4)
  );

  initial forever #5 clk_ref = ~clk_ref;

  // Square-wave source: changes a random 1..4 ns after each clk_ref rise.
  int per      = 4;
  int ph       = 0;
  bit stat_en  = 1'b0;
  bit stat_val = 1'b0;

  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk_ref);
      #($urandom_range(1, 4));
      if (stat_en) sig_in = stat_val;
      else begin
        ph     = (ph + 1) % per;
        sig_in = (ph < per - per / 2);
      end
    end
  end

  // Reference log: cycle index of every clock edge that first sees sig_in high.
  int cyc = 0;
  int rise_q[$];
  bit last_s = 1'b0;

  always @(posedge clk_ref) begin
    cyc = cyc + 1;
    if (rst) last_s = 1'b0;
    else begin
      if (sig_in && !last_s) rise_q.push_back(cyc);
      last_s = sig_in;
    end
  end

  // A rise first seen at edge k reaches the counter during cycle k+1, so a
  // window whose GATE cycles are ws..ws+GC-1 counts rises k in [ws-1, ws+GC-2].
  function automatic int model_edges(input int ws);
    int n = 0;
    foreach (rise_q[i]) if (rise_q[i] >= ws - 1 && rise_q[i] <= ws + GC - 2) n++;
    return n;
  endfunction

  function automatic int sat_of(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  // Watches one window from its first GATE cycle (ws) through its DONE cycle.
  task automatic watch_window(input string name, input int ws, input int lit8,
                              input int lit4, input int lito4, input bit pester,
                              input int chg_at, input int chg_per, input int clr_at);
    int busy_low = 0;
    int valid_early = 0;
    int exp;
    for (int c = 0; c <= GC; c++) begin
      if (c > 0) @(negedge clk_ref);
      if (pester) start = (c == 10 || c == 60 || c == GC);
      if (c == chg_at) per = chg_per;
      if (c == clr_at) cont = 1'b0;
      if (busy8 !== 1'b1) busy_low++;
      if (c < GC && valid8 !== 1'b0) valid_early++;
    end
    exp = model_edges(ws);
    n_checks++;
    if (busy_low != 0) begin
      n_errors++; $display("FAIL %s busy_drop: got %0d low cycles want 0", name, busy_low);
    end
    n_checks++;
    if (valid_early != 0) begin
      n_errors++; $display("FAIL %s valid_early: got %0d pulses want 0", name, valid_early);
    end
    n_checks++;
    if (valid8 !== 1'b1) begin
      n_errors++; $display("FAIL %s valid_at_done: got %b want 1", name, valid8);
    end
    n_checks++;
    if (freq8 !== 8'(sat_of(exp, 8)) || ovf8 !== (exp > 255)) begin
      n_errors++;
      $display("FAIL %s freq8: got %0d/%b want %0d/%b", name, freq8, ovf8, sat_of(exp, 8), exp > 255);
    end
    n_checks++;
    if (freq4 !== 4'(sat_of(exp, 4)) || ovf4 !== (exp > 15)) begin
      n_errors++;
      $display("FAIL %s freq4: got %0d/%b want %0d/%b", name, freq4, ovf4, sat_of(exp, 4), exp > 15);
    end
    if (lit8 >= 0) begin
      n_checks++;
      if (freq8 !== 8'(lit8)) begin
        n_errors++; $display("FAIL %s freq8_exact: got %0d want %0d", name, freq8, lit8);
      end
    end
    if (lit4 >= 0) begin
      n_checks++;
      if (freq4 !== 4'(lit4)) begin
        n_errors++; $display("FAIL %s freq4_exact: got %0d want %0d", name, freq4, lit4);
      end
    end
    if (lito4 >= 0) begin
      n_checks++;
      if (ovf4 !== 1'(lito4)) begin
        n_errors++; $display("FAIL %s ovf4_exact: got %b want %0d", name, ovf4, lito4);
      end
    end
  endtask

  task automatic launch(output int ws);
    start = 1'b1;
    ws    = cyc + 1;
    @(negedge clk_ref);
    start = 1'b0;
  endtask

  task automatic single_shot(input string name, input int lit8, input int lit4,
                             input int lito4, input bit pester);
    int ws, exp;
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_errors++; $display("FAIL %s idle_before: busy got %b want 0", name, busy8);
    end
    launch(ws);
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_errors++; $display("FAIL %s busy_rise: got %b want 1", name, busy8);
    end
    watch_window(name, ws, lit8, lit4, lito4, pester, -1, 0, -1);
    @(negedge clk_ref);
    start = 1'b0;
    n_checks++;
    if (busy8 !== 1'b0 || valid8 !== 1'b0) begin
      n_errors++; $display("FAIL %s after_done: busy/valid got %b/%b want 0/0", name, busy8, valid8);
    end
    exp = model_edges(ws);
    repeat (5) @(negedge clk_ref);
    n_checks++;
    if (freq8 !== 8'(sat_of(exp, 8)) || busy8 !== 1'b0) begin
      n_errors++; $display("FAIL %s freq_hold: got %0d busy %b want %0d busy 0", name, freq8, busy8, sat_of(exp, 8));
    end
  endtask

  task automatic expect_idle(input string name, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk_ref);
      if (valid8 !== 1'b0 || busy8 !== 1'b0 || valid4 !== 1'b0 || busy4 !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++; $display("FAIL %s stays_idle: got %0d active cycles want 0", name, seen);
    end
  endtask

  task automatic test_reset;
    per = 4;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk_ref);
      n_checks++;
      if ({busy8, valid8, ovf8, freq8, busy4, valid4, ovf4, freq4} !== '0) begin
        n_errors++;
        $display("FAIL reset_hold: busy %b valid %b freq %0d ovf %b want all 0", busy8, valid8, freq8, ovf8);
      end
    end
    rst = 1'b0;
    @(negedge clk_ref);
    n_checks++;
    if ({busy8, valid8, ovf8, freq8, busy4, valid4, ovf4, freq4} !== '0) begin
      n_errors++;
      $display("FAIL reset_release: busy %b valid %b freq %0d ovf %b want all 0", busy8, valid8, freq8, ovf8);
    end
    expect_idle("reset_no_start", 30);
    cont = 1'b0;
  endtask

  task automatic test_single_shot;
    per = 10;
    repeat (30) @(negedge clk_ref);
    single_shot("single_p10", 10, 10, 0, 1'b0);
  endtask

  task automatic test_overflow;
    per = 4;
    repeat (20) @(negedge clk_ref);
    single_shot("ovf_p4", 25, 15, 1, 1'b0);
    per = 10;
    repeat (20) @(negedge clk_ref);
    single_shot("ovf_then_p10", 10, 10, 0, 1'b0);
  endtask

  task automatic test_start_while_busy;
    per = 10;
    repeat (15) @(negedge clk_ref);
    single_shot("start_busy", 10, 10, 0, 1'b1);
    expect_idle("start_busy_ignored", 20);
  endtask

  task automatic test_reset_mid_gate;
    int ws;
    per = 10;
    repeat (10) @(negedge clk_ref);
    launch(ws);
    repeat (49) @(negedge clk_ref);
    rst = 1'b1;
    @(negedge clk_ref);
    n_checks++;
    if (busy8 !== 1'b0 || valid8 !== 1'b0 || freq8 !== 8'd0 || ovf8 !== 1'b0 || freq4 !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_mid_gate: busy %b valid %b freq %0d ovf %b want 0 0 0 0", busy8, valid8, freq8, ovf8);
    end
    rst = 1'b0;
    expect_idle("reset_mid_gate_no_valid", 2 * GC);
  endtask

  task automatic test_continuous;
    int ws;
    per = 5;
    repeat (20) @(negedge clk_ref);
    cont = 1'b1;
    launch(ws);
    for (int j = 0; j < 3; j++) begin
      watch_window("cont_p5", ws, 20, -1, -1, 1'b0, -1, 0, -1);
      @(negedge clk_ref);
      ws += GC + 1;
    end
    watch_window("cont_change", ws, -1, -1, -1, 1'b0, 50, 20, -1);
    @(negedge clk_ref);
    ws += GC + 1;
    watch_window("cont_p20", ws, 5, 5, 0, 1'b0, -1, 0, -1);
    @(negedge clk_ref);
    ws += GC + 1;
    watch_window("cont_last", ws, 5, 5, 0, 1'b0, -1, 0, 40);
    @(negedge clk_ref);
    n_checks++;
    if (busy8 !== 1'b0 || valid8 !== 1'b0) begin
      n_errors++; $display("FAIL cont_stop: busy/valid got %b/%b want 0/0", busy8, valid8);
    end
    expect_idle("cont_stop_quiet", 150);
  endtask

  task automatic test_static;
    stat_en  = 1'b1;
    stat_val = 1'b0;
    repeat (10) @(negedge clk_ref);
    single_shot("static_low", 0, 0, 0, 1'b0);
    stat_val = 1'b1;
    repeat (10) @(negedge clk_ref);
    single_shot("static_high", 0, 0, 0, 1'b0);
    stat_en = 1'b0;
  endtask

  task automatic test_random;
    repeat (6) begin
      per = $urandom_range(4, 40);
      ph  = $urandom_range(0, per - 1);
      repeat ($urandom_range(5, 40)) @(negedge clk_ref);
      single_shot("rand_shot", -1, -1, -1, 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    int ws;
    per = $urandom_range(4, 30);
    repeat (10) @(negedge clk_ref);
    cont = 1'b1;
    launch(ws);
    for (int j = 0; j < 4; j++) begin
      watch_window("b2b_rand", ws, -1, -1, -1, 1'b0, $urandom_range(5, 90),
                   $urandom_range(4, 30), (j == 3) ? 30 : -1);
      @(negedge clk_ref);
      ws += GC + 1;
    end
    n_checks++;
    if (busy8 !== 1'b0 || valid8 !== 1'b0) begin
      n_errors++; $display("FAIL b2b_stop: busy/valid got %b/%b want 0/0", busy8, valid8);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    cont  = 1'b1;
    test_reset;
    test_single_shot;
    test_overflow;
    test_start_while_busy;
    test_reset_mid_gate;
    test_continuous;
    test_static;
    test_random;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
